// File: rtl/matrix_result_reader_pkg.sv
// Shared matrix constants: element width/dimension defaults, element count and FSM encoding.
package matrix_result_reader_pkg;

    localparam int W_DEF = 8;
    localparam int N_DEF = 3;
    localparam int ELEMS = N_DEF * N_DEF;
    localparam int IDX_W = 4;

    localparam logic [0:0] STATE_IDLE   = 1'b0;
    localparam logic [0:0] STATE_STREAM = 1'b1;

endpackage

// File: rtl/matrix_result_reader.sv
// Captures a multiplier result matrix on Done and streams it out row-major
// over a valid/ready handshake, flagging Done pulses that arrive while busy.
module matrix_result_reader
    import matrix_result_reader_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = N_DEF
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Done,
    input  logic [W-1:0]     Out00,
    input  logic [W-1:0]     Out01,
    input  logic [W-1:0]     Out02,
    input  logic [W-1:0]     Out10,
    input  logic [W-1:0]     Out11,
    input  logic [W-1:0]     Out12,
    input  logic [W-1:0]     Out20,
    input  logic [W-1:0]     Out21,
    input  logic [W-1:0]     Out22,
    input  logic             Dout_ready,
    output logic [W-1:0]     Dout,
    output logic [IDX_W-1:0] Dout_idx,
    output logic             Dout_valid,
    output logic             Dout_last,
    output logic             Busy,
    output logic             Overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N * N - 1);

    logic [0:0]       state;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     dout_q;
    logic             overrun_q;
    logic [W-1:0]     buffer [ELEMS];
    logic [W-1:0]     in_vec [ELEMS];
    logic             streaming;
    logic             xfer;
    logic             capture;

    assign in_vec[0] = Out00;
    assign in_vec[1] = Out01;
    assign in_vec[2] = Out02;
    assign in_vec[3] = Out10;
    assign in_vec[4] = Out11;
    assign in_vec[5] = Out12;
    assign in_vec[6] = Out20;
    assign in_vec[7] = Out21;
    assign in_vec[8] = Out22;

    assign streaming = (state == STATE_STREAM);
    assign xfer      = streaming && Dout_ready;
    assign capture   = (state == STATE_IDLE) && Done && !Reset;

    // Buffer is deliberately left out of reset; it is only read while streaming.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int unsigned i = 0; i < ELEMS; i++) begin
                buffer[i] <= in_vec[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= STATE_IDLE;
            idx       <= '0;
            dout_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (Done && streaming) begin
                overrun_q <= 1'b1;
            end
            case (state)
                STATE_IDLE: begin
                    if (Done) begin
                        state  <= STATE_STREAM;
                        idx    <= '0;
                        dout_q <= in_vec[0];
                    end
                end
                STATE_STREAM: begin
                    if (xfer) begin
                        // Final transfer leaves Dout/Dout_idx on the last element.
                        if (idx == LAST_IDX) begin
                            state <= STATE_IDLE;
                        end else begin
                            idx    <= idx + 1'b1;
                            dout_q <= buffer[idx + 1'b1];
                        end
                    end
                end
                default: state <= STATE_IDLE;
            endcase
        end
    end

    assign Dout       = dout_q;
    assign Dout_idx   = idx;
    assign Dout_valid = streaming;
    assign Dout_last  = streaming && (idx == LAST_IDX);
    assign Busy       = streaming;
    assign Overrun    = overrun_q;

endmodule

// File: tb/tb_matrix_result_reader.sv
// Randomized and directed checks of matrix_result_reader against a queue/array reference model.
module tb_matrix_result_reader;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Done = 1'b0;
    logic       Dout_ready = 1'b0;
    logic [7:0] ins [9];
    logic [7:0] Dout;
    logic [3:0] Dout_idx;
    logic       Dout_valid;
    logic       Dout_last;
    logic       Busy;
    logic       Overrun;

    int tests = 0;
    int fails = 0;

    // Reference model: matrix snapshot, position in it, and sticky error flag.
    bit         m_busy = 1'b0;
    int         m_pos = 0;
    logic [7:0] m_mat [9];
    bit         m_over = 1'b0;
    logic [7:0] m_dout = '0;
    int         m_idx = 0;
    logic [7:0] dut_acc [$];

    always #5 clk = ~clk;

    matrix_result_reader #(.W(8), .N(3)) dut (
        .clk(clk), .Reset(Reset), .Done(Done),
        .Out00(ins[0]), .Out01(ins[1]), .Out02(ins[2]),
        .Out10(ins[3]), .Out11(ins[4]), .Out12(ins[5]),
        .Out20(ins[6]), .Out21(ins[7]), .Out22(ins[8]),
        .Dout_ready(Dout_ready), .Dout(Dout), .Dout_idx(Dout_idx),
        .Dout_valid(Dout_valid), .Dout_last(Dout_last), .Busy(Busy), .Overrun(Overrun)
    );

    task automatic step(input bit rst, input bit done, input bit rdy);
        bit was_busy;
        Reset = rst;
        Done = done;
        Dout_ready = rdy;
        if (Dout_valid && rdy && !rst) dut_acc.push_back(Dout);
        @(posedge clk);
        was_busy = m_busy;
        if (rst) begin
            m_busy = 0; m_pos = 0; m_over = 0; m_dout = '0; m_idx = 0;
        end else begin
            if (done && was_busy) m_over = 1;
            if (was_busy && rdy) begin
                if (m_pos == 8) m_busy = 0;
                else begin
                    m_pos++;
                    m_dout = m_mat[m_pos];
                    m_idx = m_pos;
                end
            end
            if (done && !was_busy) begin
                for (int i = 0; i < 9; i++) m_mat[i] = ins[i];
                m_busy = 1; m_pos = 0; m_dout = m_mat[0]; m_idx = 0;
            end
        end
        #1;
        Done = 1'b0;
        Reset = 1'b0;
    endtask

    task automatic set_random_ins();
        for (int i = 0; i < 9; i++) ins[i] = 8'($urandom);
    endtask

    task automatic test_reset();
        step(1, 0, 0);
        step(1, 1, 1);
        tests++; if (Dout !== 8'h00) begin fails++; $display("FAIL reset_dout got=%h exp=00", Dout); end
        tests++; if (Dout_idx !== 4'd0) begin fails++; $display("FAIL reset_idx got=%0d exp=0", Dout_idx); end
        tests++; if (Dout_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", Dout_valid); end
        tests++; if (Dout_last !== 1'b0) begin fails++; $display("FAIL reset_last got=%b exp=0", Dout_last); end
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        tests++; if (Overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got=%b exp=0", Overrun); end
    endtask

    task automatic test_basic_drain();
        step(1, 0, 1);
        for (int i = 0; i < 9; i++) ins[i] = 8'(i + 1);
        step(0, 1, 1);
        dut_acc.delete();
        for (int k = 0; k < 9; k++) begin
            tests++; if (Dout !== 8'(k + 1)) begin fails++; $display("FAIL drain_dout k=%0d got=%h exp=%h", k, Dout, 8'(k + 1)); end
            tests++; if (Dout_idx !== 4'(k)) begin fails++; $display("FAIL drain_idx k=%0d got=%0d exp=%0d", k, Dout_idx, k); end
            tests++; if (Dout_valid !== 1'b1) begin fails++; $display("FAIL drain_valid k=%0d got=%b exp=1", k, Dout_valid); end
            tests++; if (Dout_last !== (k == 8)) begin fails++; $display("FAIL drain_last k=%0d got=%b exp=%b", k, Dout_last, k == 8); end
            step(0, 0, 1);
        end
        tests++; if (Busy !== 1'b0 || Dout_valid !== 1'b0) begin fails++; $display("FAIL drain_end busy=%b valid=%b exp=0/0", Busy, Dout_valid); end
        tests++; if (dut_acc.size() != 9) begin fails++; $display("FAIL drain_count got=%0d exp=9", dut_acc.size()); end
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [7:0] pd;
        logic [3:0] pi;
        step(1, 0, 1);
        for (int i = 0; i < 9; i++) ins[i] = 8'(i + 1);
        step(0, 1, 0);
        dut_acc.delete();
        cyc = 0;
        while (Busy && cyc < 40) begin
            pd = Dout;
            pi = Dout_idx;
            step(0, 0, cyc[0]);
            if (!cyc[0]) begin
                tests++;
                if (Dout !== pd || Dout_idx !== pi || Dout_valid !== 1'b1) begin
                    fails++; $display("FAIL bp_stall cyc=%0d got=%h/%0d/%b exp=%h/%0d/1", cyc, Dout, Dout_idx, Dout_valid, pd, pi);
                end
            end
            cyc++;
        end
        tests++; if (cyc != 18) begin fails++; $display("FAIL bp_cycles got=%0d exp=18", cyc); end
        tests++; if (dut_acc.size() != 9) begin fails++; $display("FAIL bp_count got=%0d exp=9", dut_acc.size()); end
        for (int k = 0; k < dut_acc.size() && k < 9; k++) begin
            tests++; if (dut_acc[k] !== 8'(k + 1)) begin fails++; $display("FAIL bp_order k=%0d got=%h exp=%h", k, dut_acc[k], 8'(k + 1)); end
        end
    endtask

    task automatic test_overrun();
        step(1, 0, 1);
        for (int i = 0; i < 9; i++) ins[i] = 8'h50;
        step(0, 1, 1);
        dut_acc.delete();
        for (int k = 0; k < 9; k++) begin
            if (k == 3) for (int i = 0; i < 9; i++) ins[i] = 8'hFF;
            step(0, k == 3, 1);
            tests++; if (Overrun !== (k >= 3)) begin fails++; $display("FAIL ovr_flag k=%0d got=%b exp=%b", k, Overrun, k >= 3); end
        end
        tests++; if (dut_acc.size() != 9) begin fails++; $display("FAIL ovr_count got=%0d exp=9", dut_acc.size()); end
        for (int k = 0; k < dut_acc.size(); k++) begin
            tests++; if (dut_acc[k] !== 8'h50) begin fails++; $display("FAIL ovr_data k=%0d got=%h exp=50", k, dut_acc[k]); end
        end
        for (int k = 0; k < 3; k++) step(0, 0, 1);
        tests++; if (Overrun !== 1'b1 || Busy !== 1'b0) begin fails++; $display("FAIL ovr_sticky ovr=%b busy=%b exp=1/0", Overrun, Busy); end
    endtask

    task automatic test_done_last();
        step(1, 0, 1);
        set_random_ins();
        step(0, 1, 1);
        for (int k = 0; k < 9; k++) step(0, k == 8, 1);
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL last_busy got=%b exp=0", Busy); end
        tests++; if (Overrun !== 1'b1) begin fails++; $display("FAIL last_overrun got=%b exp=1", Overrun); end
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1);
            tests++; if (Dout_valid !== 1'b0) begin fails++; $display("FAIL last_nostream k=%0d got=%b exp=0", k, Dout_valid); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [9];
        step(1, 0, 1);
        set_random_ins();
        step(0, 1, 1);
        for (int k = 0; k < 4; k++) step(0, k == 2, 1);
        tests++; if (Dout_idx !== 4'd4 || Overrun !== 1'b1) begin fails++; $display("FAIL mid_pre idx=%0d ovr=%b exp=4/1", Dout_idx, Overrun); end
        step(1, 0, 1);
        tests++; if (Dout_valid !== 1'b0 || Busy !== 1'b0 || Overrun !== 1'b0) begin
            fails++; $display("FAIL mid_reset valid=%b busy=%b ovr=%b exp=0/0/0", Dout_valid, Busy, Overrun);
        end
        set_random_ins();
        for (int i = 0; i < 9; i++) exp[i] = ins[i];
        step(0, 1, 1);
        tests++; if (Dout_idx !== 4'd0 || Dout !== exp[0] || Dout_valid !== 1'b1) begin
            fails++; $display("FAIL mid_restart idx=%0d dout=%h valid=%b exp=0/%h/1", Dout_idx, Dout, Dout_valid, exp[0]);
        end
        dut_acc.delete();
        for (int k = 0; k < 9; k++) step(0, 0, 1);
        for (int k = 0; k < 9; k++) begin
            tests++; if (k >= dut_acc.size() || dut_acc[k] !== exp[k]) begin fails++; $display("FAIL mid_data k=%0d exp=%h", k, exp[k]); end
        end
    endtask

    task automatic test_ready_low();
        logic [7:0] first;
        step(1, 0, 0);
        set_random_ins();
        first = ins[0];
        step(0, 1, 0);
        for (int k = 0; k < 20; k++) begin
            tests++; if (Dout_idx !== 4'd0 || Dout !== first || Dout_valid !== 1'b1) begin
                fails++; $display("FAIL rdylow k=%0d idx=%0d dout=%h valid=%b exp=0/%h/1", k, Dout_idx, Dout, Dout_valid, first);
            end
            step(0, 0, 0);
        end
        for (int k = 0; k < 9; k++) step(0, 0, 1);
    endtask

    task automatic test_random();
        bit r, d, y;
        step(1, 0, 0);
        for (int c = 0; c < 500; c++) begin
            r = ($urandom_range(0, 59) == 0);
            d = ($urandom_range(0, 7) == 0);
            y = ($urandom_range(0, 2) != 0);
            set_random_ins();
            step(r, d, y);
            tests++;
            if (Dout_valid !== m_busy || Busy !== m_busy || Overrun !== m_over ||
                Dout_last !== (m_busy && m_pos == 8) || Dout_idx !== 4'(m_idx) || Dout !== m_dout) begin
                fails++;
                $display("FAIL rand c=%0d got v=%b b=%b o=%b l=%b i=%0d d=%h exp v=%b o=%b i=%0d d=%h",
                         c, Dout_valid, Busy, Overrun, Dout_last, Dout_idx, Dout, m_busy, m_over, m_idx, m_dout);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 9; i++) ins[i] = '0;
        test_reset();
        test_basic_drain();
        test_backpressure();
        test_overrun();
        test_done_last();
        test_reset_mid();
        test_ready_low();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/matrix_result_reader.md
MATRIX_RESULT_READER -- requirements
Module: matrix_result_reader

Interface
REQ-001 The block SHALL use one clock, clk; reset is synchronous and active-high, named Reset.
REQ-002 Parameter W, default 8: the width of one matrix element.
REQ-003 Parameter N, default 3: the matrix dimension; there are N*N elements.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Done  input  1  one-cycle pulse from the multiplier; the result matrix is valid in this cycle.
REQ-007 Out00..Out22  input  W each  the nine result elements from the multiplier, row-major names.
REQ-008 Dout  output  W  the element currently offered to the consumer.
REQ-009 Dout_idx  output  4  row-major index of Dout, 0..8 (row*N+col).
REQ-010 Dout_valid  output  1  Dout and Dout_idx are valid.
REQ-011 Dout_ready  input  1  the consumer accepts Dout in this cycle.
REQ-012 Dout_last  output  1  high together with Dout_valid when Dout_idx is 8.
REQ-013 Busy  output  1  a captured matrix is not yet fully drained.
REQ-014 Overrun  output  1  sticky flag: a Done pulse arrived while Busy.

Function
REQ-015 The FSM SHALL have two states: IDLE and STREAM.
REQ-016 IDLE + Done=1: on that edge, capture all nine inputs into an internal buffer, set index=0, and go to STREAM.
REQ-017 In STREAM, Dout_valid=1, Dout=buffer[index], and Dout_idx=index.
REQ-018 Transfer: a transfer occurs on an edge where Dout_valid=1 and Dout_ready=1; the index then increments.
REQ-019 Stall: while Dout_ready=0, Dout, Dout_idx and Dout_valid SHALL hold stable.
REQ-020 Final transfer: a transfer at index 8 returns the FSM to IDLE; Dout_valid=0 in the next cycle.
REQ-021 Latency: the first Dout_valid is asserted in the cycle after Done; with Dout_ready held at 1, the full matrix drains in 9 consecutive cycles.
REQ-022 Busy SHALL equal (state==STREAM).
REQ-023 Done while in STREAM:
- the buffer is not modified and the stream continues;
- Overrun is set to 1 and stays 1 until Reset.
REQ-024 Done on the same edge as the final transfer (index 8): this counts as Busy, so Overrun is set and the new matrix is dropped.
REQ-025 Index arithmetic SHALL be 4-bit unsigned; values 9..15 are unreachable and SHALL never be presented.
REQ-026 Element data SHALL pass through bit-exact, with no arithmetic applied.
REQ-027 In IDLE, Dout and Dout_idx SHALL hold their last values; consumers qualify them with Dout_valid only.

Reset
REQ-028 Reset SHALL put the FSM in IDLE and clear the index to 0.
REQ-029 After Reset, Dout=0, Dout_idx=0, Dout_valid=0, Dout_last=0, Busy=0 and Overrun=0 from the next cycle.
REQ-030 Reset during STREAM SHALL abort the stream and discard the buffer.
REQ-031 Reset SHALL take priority over a simultaneous Done.
REQ-032 The buffer contents need not be cleared by Reset.

Structure
REQ-033 The shared matrix package SHALL hold:
- the W and N defaults;
- the element-count constant (N*N = 9);
- the state encoding for IDLE and STREAM.
REQ-034 No sub-module is required.
REQ-035 The buffer SHALL be an internal register array indexed by the row-major index.

Verification
REQ-036 Basic drain: after Reset, pulse Done with Out00..Out22 = 1..9 and hold Dout_ready=1 -> Dout = 1..9 on nine consecutive cycles, Dout_idx = 0..8, Dout_last high only at 9, then Busy=0.
REQ-037 Backpressure: same data, with Dout_ready low on alternate cycles -> each element is held until accepted, the order is unchanged, and 18 cycles are needed in total.
REQ-038 Overrun: pulse Done with every input = 8'h50, then pulse Done again at index 3 with every input = 8'hFF -> all nine outputs are 8'h50 and Overrun=1 persists afterward.
REQ-039 Done on the last edge: Done coincides with the transfer at index 8 -> the FSM goes to IDLE, Overrun=1, and no second stream follows.
REQ-040 Reset mid-stream: assert Reset at index 4 -> Dout_valid=0, Busy=0 and Overrun=0 next cycle; a following Done starts a fresh stream at index 0.
REQ-041 Ready held low: hold Dout_ready=0 for 20 cycles after Done -> Dout_idx stays 0 and Dout holds Out00 throughout.
